// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 2K x 2K multiplier controller.
//   K_DEF    default core operand width (64 x 64 -> 128 on a 32-bit core)
//   state_e  controller state encoding (3 bits)
//   shift_w  width of a shift-amount field able to hold 0..2K
package mult_pkg;

  localparam int K_DEF = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    DONE = 3'd5
  } state_e;

  function automatic int shift_w(input int k);
    return $clog2(2 * k + 1);
  endfunction

endpackage

// File: rtl/mult_pp_sel.sv
// Partial-product selector: picks which operand halves feed the external
// K x K core for the current state, and how far the core result must be
// shifted before it joins the accumulator.
//   state      current controller state
//   a, b       registered 2K-bit operands
//   core_x/y   K-bit core operands (0 outside PP0..PP3)
//   shift      left shift applied to the core result (0, K, K, 2K)
//   pp_active  high in PP0..PP3, i.e. when the core result is accumulated
module mult_pp_sel
  import mult_pkg::*;
#(
  parameter int K    = K_DEF,
  parameter int SH_W = shift_w(K_DEF)
) (
  input  state_e          state,
  input  logic [2*K-1:0]  a,
  input  logic [2*K-1:0]  b,
  output logic [K-1:0]    core_x,
  output logic [K-1:0]    core_y,
  output logic [SH_W-1:0] shift,
  output logic            pp_active
);

  logic [K-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = a[K-1:0];
  assign a_hi = a[2*K-1:K];
  assign b_lo = b[K-1:0];
  assign b_hi = b[2*K-1:K];

  always_comb begin
    core_x    = '0;
    core_y    = '0;
    shift     = '0;
    pp_active = 1'b0;
    case (state)
      PP0: begin
        core_x    = a_lo;
        core_y    = b_lo;
        pp_active = 1'b1;
      end
      PP1: begin
        core_x    = a_lo;
        core_y    = b_hi;
        shift     = SH_W'(K);
        pp_active = 1'b1;
      end
      PP2: begin
        core_x    = a_hi;
        core_y    = b_lo;
        shift     = SH_W'(K);
        pp_active = 1'b1;
      end
      PP3: begin
        core_x    = a_hi;
        core_y    = b_hi;
        shift     = SH_W'(2 * K);
        pp_active = 1'b1;
      end
      default: begin
        core_x    = '0;
        core_y    = '0;
        shift     = '0;
        pp_active = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult64_seq_ctrl.sv
// Sequential controller computing an unsigned 2K x 2K -> 4K product using an
// external combinational K x K core, one partial product per cycle.
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a/in_b 2K-bit operands
//   core_x/core_y/core_z  external core interface (core_z combinational)
//   out_valid/out_ready   product handshake, out_p 4K-bit product
//   busy                  high whenever the controller is not IDLE
module mult64_seq_ctrl
  import mult_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*K-1:0] in_a,
  input  logic [2*K-1:0] in_b,
  output logic [K-1:0]   core_x,
  output logic [K-1:0]   core_y,
  input  logic [2*K-1:0] core_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*K-1:0] out_p,
  output logic           busy
);

  localparam int SH_W = shift_w(K);
  localparam int AW   = 4 * K;

  state_e          state_q, state_d;
  logic [2*K-1:0]  a_q, a_d;
  logic [2*K-1:0]  b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [SH_W-1:0] shift;
  logic            pp_active;
  logic [AW-1:0]   pp_shifted;
  logic            accept;

  // Core operands depend only on registered state/operands, so the core
  // sees stable inputs for the whole cycle.
  mult_pp_sel #(
    .K    (K),
    .SH_W (SH_W)
  ) u_pp_sel (
    .state     (state_q),
    .a         (a_q),
    .b         (b_q),
    .core_x    (core_x),
    .core_y    (core_y),
    .shift     (shift),
    .pp_active (pp_active)
  );

  // in_ready is forced low while reset is held so nothing is accepted
  // during the reset window.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  assign pp_shifted = AW'(core_z) << shift;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;

    if (pp_active) begin
      acc_d = acc_q + pp_shifted;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PP0;
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
        end
      end
      PP0:  state_d = PP1;
      PP1:  state_d = PP2;
      PP2:  state_d = PP3;
      PP3:  state_d = DONE;
      DONE: begin
        // A product transfer and a new accept on the same edge both take
        // effect: the next operation starts in PP0 with no bubble.
        if (accept) begin
          state_d = PP0;
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_p     = acc_q;

endmodule

// File: tb/tb_mult64_seq_ctrl.sv
// Directed and random bench for mult64_seq_ctrl (K = 32) with a bench-side
// 32 x 32 core and a golden 128-bit product.
module tb_mult64_seq_ctrl;

  localparam int K = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*K-1:0] in_a = '0;
  logic [2*K-1:0] in_b = '0;
  logic [K-1:0]   core_x;
  logic [K-1:0]   core_y;
  logic [2*K-1:0] core_z;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4*K-1:0] out_p;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;
  int xfers  = 0;

  mult64_seq_ctrl #(.K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_z    (core_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  assign core_z = {32'b0, core_x} * {32'b0, core_y};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !out_valid; i++) step();
    chk(tag, 128'(out_valid), 128'd1);
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [127:0] exp);
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 12 && !in_ready; i++) step();
    chk({tag, "_ready"}, 128'(in_ready), 128'd1);
    step();
    in_valid = 1'b0;
    wait_valid({tag, "_valid"});
    chk({tag, "_p"}, out_p, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 128'(out_valid), 128'd0);
  endtask

  logic [127:0] q[$];
  logic [127:0] exp_p;
  int           x0;
  int           sent;
  int           recv;
  int           cyc;
  bit           pending;

  initial begin
    // 1. reset state and a first product with latency checks
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_core_x", 128'(core_x), 128'd0);
    chk("rst_out_p", out_p, 128'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    in_a = 64'd3;
    in_b = 64'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_busy", 128'(busy), 128'd1);
    chk("t1_in_ready", 128'(in_ready), 128'd0);
    chk("t1_core_x", 128'(core_x), 128'd3);
    chk("t1_core_y", 128'(core_y), 128'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_early_valid", 128'(out_valid), 128'd0);
      chk("t1_busy_ready", 128'(in_ready), 128'd0);
    end
    step();
    chk("t1_valid_edge5", 128'(out_valid), 128'd1);
    chk("t1_p", out_p, 128'd15);
    chk("t1_done_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    #1;
    chk("t1_done_ready_or", 128'(in_ready), 128'd1);
    x0 = xfers;
    step();
    out_ready = 1'b0;
    chk("t1_after_valid", 128'(out_valid), 128'd0);
    chk("t1_after_busy", 128'(busy), 128'd0);
    chk("t1_xfer", 128'(xfers - x0), 128'd1);

    // 2. all-ones operands
    do_op("t2_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_op("t2_zero", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0);
    do_op("t2_mix", 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
          128'h0000_0000_0000_0003_0000_000A_0000_0008);

    // 3. sink stall in DONE with a new pair waiting
    in_a = 64'h10;
    in_b = 64'h20;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_a = 64'hDEAD;
    in_b = 64'hBEEF;
    wait_valid("t3_valid");
    x0 = xfers;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t3_hold_valid", 128'(out_valid), 128'd1);
      chk("t3_hold_p", out_p, 128'h200);
      chk("t3_hold_ready", 128'(in_ready), 128'd0);
    end
    chk("t3_no_xfer", 128'(xfers - x0), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t3_rel_valid", 128'(out_valid), 128'd0);
    chk("t3_rel_busy", 128'(busy), 128'd0);
    step();
    out_ready = 1'b0;
    chk("t3_one_xfer", 128'(xfers - x0), 128'd1);

    // 4. back-to-back accept on the same edge as a product transfer
    in_a = 64'h1_0000_0000;
    in_b = 64'h1_0000_0000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_a = 64'h1234;
    in_b = 64'h0;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("t4_valid1", 128'(out_valid), 128'd1);
    chk("t4_p1", out_p, 128'h1_0000_0000_0000_0000);
    chk("t4_ready_done", 128'(in_ready), 128'd1);
    x0 = xfers;
    step();
    in_valid = 1'b0;
    chk("t4_xfer1", 128'(xfers - x0), 128'd1);
    chk("t4_nobubble_busy", 128'(busy), 128'd1);
    chk("t4_nobubble_valid", 128'(out_valid), 128'd0);
    chk("t4_core_x", 128'(core_x), 128'h1234);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("t4_valid2", 128'(out_valid), 128'd1);
    chk("t4_p2", out_p, 128'd0);
    step();
    out_ready = 1'b0;
    chk("t4_xfer2", 128'(xfers - x0), 128'd2);
    chk("t4_idle", 128'(busy), 128'd0);

    // 5. asynchronous reset during PP2
    in_a = 64'hABCD;
    in_b = 64'h1234;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("t5_pp2_busy", 128'(busy), 128'd1);
    x0 = xfers;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 128'(busy), 128'd0);
    chk("t5_rst_valid", 128'(out_valid), 128'd0);
    chk("t5_rst_core", 128'(core_x), 128'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t5_no_product", 128'(xfers - x0), 128'd0);
    chk("t5_idle_valid", 128'(out_valid), 128'd0);
    do_op("t5_7x9", 64'd7, 64'd9, 128'd63);

    // 6. random operands with random source and sink stalls
    sent = 0;
    recv = 0;
    cyc = 0;
    pending = 1'b0;
    in_valid = 1'b0;
    while ((sent < 10000 || recv < 10000) && cyc < 90000) begin
      out_ready = ($urandom_range(7) != 0);
      if (!pending && sent < 10000 && $urandom_range(7) != 0) begin
        in_a = {$urandom(), $urandom()};
        if ($urandom_range(15) == 0) in_a = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b = {$urandom(), $urandom()};
        pending = 1'b1;
      end
      in_valid = pending;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("t6_dup_xfer", 128'd1, 128'd0);
        end else begin
          exp_p = q.pop_front();
          chk("t6_p", out_p, exp_p);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back({64'b0, in_a} * {64'b0, in_b});
        pending = 1'b0;
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("t6_sent", 128'(sent), 128'd10000);
    chk("t6_recv", 128'(recv), 128'd10000);
    chk("t6_queue_empty", 128'(q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
